// File: rtl/acis_ctrl_pkg.sv
// Shared types and defaults for the ACiS column control sequencer.
// State-word layout, FSM encoding and iterator-select codes live here.
package acis_ctrl_pkg;

   localparam int NUM_COL_DEF = 4;
   localparam int PHIT_W_DEF  = 64;
   localparam int CTRL_W_DEF  = 24;
   localparam int DEPTH_DEF   = 16;
   localparam int LOOP_W_DEF  = 16;

   localparam logic [1:0] ITR_SEL_I    = 2'd0;
   localparam logic [1:0] ITR_SEL_J    = 2'd1;
   localparam logic [1:0] ITR_SEL_K    = 2'd2;
   localparam logic [1:0] ITR_SEL_BEAT = 2'd3;

   // MSB-first packing matches the state word: {last, itr_sel, i, j, k}
   typedef struct packed {
      logic                  last;
      logic [1:0]            itr_sel;
      logic [LOOP_W_DEF-1:0] bound_i;
      logic [LOOP_W_DEF-1:0] bound_j;
      logic [LOOP_W_DEF-1:0] bound_k;
   } state_entry_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_LOADED,
      ST_FETCH,
      ST_RUN,
      ST_DONE
   } seq_state_e;

endpackage

// File: rtl/loop_nest_counter.sv
// Three-level (i,j,k) iteration counter with k innermost, plus a linear beat
// count; clr has priority over adv.
module loop_nest_counter
   import acis_ctrl_pkg::*;
#(
   parameter int LOOP_W = LOOP_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_clr,
   input  logic              i_adv,
   input  logic [LOOP_W-1:0] i_bound_i,
   input  logic [LOOP_W-1:0] i_bound_j,
   input  logic [LOOP_W-1:0] i_bound_k,
   output logic [LOOP_W-1:0] o_i,
   output logic [LOOP_W-1:0] o_j,
   output logic [LOOP_W-1:0] o_k,
   output logic [LOOP_W-1:0] o_beat,
   output logic              o_last
);

   logic [LOOP_W-1:0] r_i, r_j, r_k, r_beat;
   logic              w_i_end, w_j_end, w_k_end;

   assign w_i_end = (r_i == i_bound_i - LOOP_W'(1));
   assign w_j_end = (r_j == i_bound_j - LOOP_W'(1));
   assign w_k_end = (r_k == i_bound_k - LOOP_W'(1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_i    <= '0;
         r_j    <= '0;
         r_k    <= '0;
         r_beat <= '0;
      end else if (i_clr) begin
         r_i    <= '0;
         r_j    <= '0;
         r_k    <= '0;
         r_beat <= '0;
      end else if (i_adv) begin
         r_beat <= r_beat + LOOP_W'(1);
         if (!w_k_end) begin
            r_k <= r_k + LOOP_W'(1);
         end else begin
            r_k <= '0;
            if (!w_j_end) begin
               r_j <= r_j + LOOP_W'(1);
            end else begin
               r_j <= '0;
               r_i <= w_i_end ? '0 : r_i + LOOP_W'(1);
            end
         end
      end
   end

   assign o_i    = r_i;
   assign o_j    = r_j;
   assign o_k    = r_k;
   assign o_beat = r_beat;
   assign o_last = w_i_end && w_j_end && w_k_end;

endmodule

// File: rtl/ctrl_sequencer.sv
// ACiS column control sequencer: loads state/ctrl/imm tables from a phit
// stream, then walks each entry's i/j/k loop nest issuing one beat per step.
module ctrl_sequencer
   import acis_ctrl_pkg::*;
#(
   parameter int NUM_COL = NUM_COL_DEF,
   parameter int PHIT_W  = PHIT_W_DEF,
   parameter int CTRL_W  = CTRL_W_DEF,
   parameter int DEPTH   = DEPTH_DEF,
   parameter int LOOP_W  = LOOP_W_DEF,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      load_start,
   input  logic [ADDR_W:0]           load_num_entry,
   input  logic [PHIT_W-1:0]         wr_data,
   input  logic                      wr_valid,
   output logic                      wr_ready,
   output logic                      load_done,
   input  logic                      run_start,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [NUM_COL*CTRL_W-1:0] out_ctrl,
   output logic [NUM_COL*PHIT_W-1:0] out_imm,
   output logic [LOOP_W-1:0]         out_itr,
   output logic [3*LOOP_W-1:0]       out_itr_all,
   output logic [ADDR_W-1:0]         out_ptr,
   output logic                      out_last_beat,
   output logic                      busy,
   output logic                      done,
   output logic                      err
);

   localparam int SW     = 3*LOOP_W + 3;
   localparam int WPE    = 1 + 2*NUM_COL;
   localparam int WCNT_W = $clog2(WPE);

   if (SW > PHIT_W) begin : g_bad_loop_w
      $error("ctrl_sequencer: 3*LOOP_W+3 must not exceed PHIT_W");
   end
   if (CTRL_W > PHIT_W) begin : g_bad_ctrl_w
      $error("ctrl_sequencer: CTRL_W must not exceed PHIT_W");
   end

   logic [SW-1:0]     r_state_tab [DEPTH];
   logic [CTRL_W-1:0] r_ctrl_tab  [NUM_COL][DEPTH];
   logic [PHIT_W-1:0] r_imm_tab   [NUM_COL][DEPTH];

   seq_state_e        r_state, w_next;
   logic [ADDR_W:0]   r_num;
   logic [ADDR_W-1:0] r_ptr, r_ecnt;
   logic [WCNT_W-1:0] r_wcnt;
   logic              r_loaded, r_load_done, r_err;

   logic [SW-1:0]     w_ent;
   logic [LOOP_W-1:0] w_bi, w_bj, w_bk;
   logic [1:0]        w_sel;
   logic              w_last, w_zero, w_ptr_end, w_n_ok;
   logic              w_wr_acc, w_wr_final, w_hs, w_run;
   logic              w_err_set, w_ptr_clr, w_ptr_inc, w_cnt_clr, w_load_go;
   logic [LOOP_W-1:0] w_i, w_j, w_k, w_beat;
   logic              w_lc_last;

   assign w_ent     = r_state_tab[r_ptr];
   assign w_bk      = w_ent[LOOP_W-1:0];
   assign w_bj      = w_ent[2*LOOP_W-1:LOOP_W];
   assign w_bi      = w_ent[3*LOOP_W-1:2*LOOP_W];
   assign w_sel     = w_ent[3*LOOP_W+1:3*LOOP_W];
   assign w_last    = w_ent[3*LOOP_W+2];
   assign w_zero    = (w_bi == '0) || (w_bj == '0) || (w_bk == '0);
   assign w_ptr_end = ({1'b0, r_ptr} == r_num - (ADDR_W+1)'(1));
   assign w_n_ok    = (load_num_entry != '0) && (load_num_entry <= (ADDR_W+1)'(DEPTH));

   assign w_wr_acc   = (r_state == ST_LOAD) && wr_valid;
   assign w_wr_final = w_wr_acc && (r_wcnt == WCNT_W'(WPE-1)) &&
                       ({1'b0, r_ecnt} == r_num - (ADDR_W+1)'(1));
   assign w_run      = (r_state == ST_RUN);
   assign w_hs       = w_run && out_ready;

   always_comb begin
      w_next    = r_state;
      w_err_set = 1'b0;
      w_ptr_clr = 1'b0;
      w_ptr_inc = 1'b0;
      w_cnt_clr = 1'b0;
      w_load_go = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (load_start) begin
               if (w_n_ok) begin
                  w_next    = ST_LOAD;
                  w_load_go = 1'b1;
               end else begin
                  w_err_set = 1'b1;
               end
            end else if (run_start) begin
               w_err_set = 1'b1;
            end
         end
         ST_LOAD: begin
            if (w_wr_final) w_next = ST_LOADED;
         end
         ST_LOADED: begin
            // load_start outranks run_start when both arrive together
            if (load_start) begin
               if (w_n_ok) begin
                  w_next    = ST_LOAD;
                  w_load_go = 1'b1;
               end else begin
                  w_err_set = 1'b1;
               end
            end else if (run_start) begin
               if (r_loaded) begin
                  w_next    = ST_FETCH;
                  w_ptr_clr = 1'b1;
                  w_cnt_clr = 1'b1;
               end else begin
                  w_err_set = 1'b1;
               end
            end
         end
         ST_FETCH: begin
            w_cnt_clr = 1'b1;
            if (!w_zero) begin
               w_next = ST_RUN;
            end else if (w_last || w_ptr_end) begin
               w_next = ST_DONE;
            end else begin
               w_ptr_inc = 1'b1;
            end
         end
         ST_RUN: begin
            if (w_hs && w_lc_last) begin
               if (w_last || w_ptr_end) begin
                  w_next = ST_DONE;
               end else begin
                  w_next    = ST_FETCH;
                  w_ptr_inc = 1'b1;
                  w_cnt_clr = 1'b1;
               end
            end
         end
         ST_DONE:  w_next = ST_LOADED;
         default:  w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_num       <= '0;
         r_ptr       <= '0;
         r_ecnt      <= '0;
         r_wcnt      <= '0;
         r_loaded    <= 1'b0;
         r_load_done <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_err       <= w_err_set;
         r_load_done <= w_wr_final;
         if (w_load_go) begin
            r_num    <= load_num_entry;
            r_ecnt   <= '0;
            r_wcnt   <= '0;
            r_loaded <= 1'b0;
         end else if (w_wr_acc) begin
            if (r_wcnt == WCNT_W'(WPE-1)) begin
               r_wcnt <= '0;
               r_ecnt <= r_ecnt + ADDR_W'(1);
            end else begin
               r_wcnt <= r_wcnt + WCNT_W'(1);
            end
         end
         if (w_wr_final) r_loaded <= 1'b1;
         if (w_ptr_clr)      r_ptr <= '0;
         else if (w_ptr_inc) r_ptr <= r_ptr + ADDR_W'(1);
      end
   end

   // Word 0 of an entry is the state word; then ctrl_c/imm_c pairs per column.
   always_ff @(posedge clk) begin
      if (w_wr_acc) begin
         if (r_wcnt == '0) r_state_tab[r_ecnt] <= wr_data[SW-1:0];
         for (int c = 0; c < NUM_COL; c++) begin
            if (r_wcnt == WCNT_W'(2*c+1)) r_ctrl_tab[c][r_ecnt] <= wr_data[CTRL_W-1:0];
            if (r_wcnt == WCNT_W'(2*c+2)) r_imm_tab[c][r_ecnt]  <= wr_data;
         end
      end
   end

   loop_nest_counter #(.LOOP_W(LOOP_W)) u_nest (
      .clk       (clk),
      .rst       (rst),
      .i_clr     (w_cnt_clr),
      .i_adv     (w_hs),
      .i_bound_i (w_bi),
      .i_bound_j (w_bj),
      .i_bound_k (w_bk),
      .o_i       (w_i),
      .o_j       (w_j),
      .o_k       (w_k),
      .o_beat    (w_beat),
      .o_last    (w_lc_last)
   );

   // Data outputs are gated to RUN so the unreset tables never leak out.
   always_comb begin
      out_ctrl = '0;
      out_imm  = '0;
      out_itr  = '0;
      if (w_run) begin
         for (int c = 0; c < NUM_COL; c++) begin
            out_ctrl[c*CTRL_W +: CTRL_W] = r_ctrl_tab[c][r_ptr];
            out_imm[c*PHIT_W +: PHIT_W]  = r_imm_tab[c][r_ptr];
         end
         case (w_sel)
            ITR_SEL_I: out_itr = w_i;
            ITR_SEL_J: out_itr = w_j;
            ITR_SEL_K: out_itr = w_k;
            default:   out_itr = w_beat;
         endcase
      end
   end

   assign out_itr_all   = w_run ? {w_i, w_j, w_k} : '0;
   assign out_last_beat = w_run && w_lc_last;
   assign out_valid     = w_run;
   assign out_ptr       = r_ptr;
   assign wr_ready      = (r_state == ST_LOAD);
   assign busy          = (r_state == ST_LOAD) || (r_state == ST_FETCH) || w_run;
   assign done          = (r_state == ST_DONE);
   assign load_done     = r_load_done;
   assign err           = r_err;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed bench for ctrl_sequencer (NUM_COL=2): load, loop-nest run,
// backpressure, zero-trip/last, error commands, reset and rerun.
module tb_ctrl_sequencer;
   import acis_ctrl_pkg::*;

   localparam int NC = 2, PW = 64, CW = 24, DP = 16, LW = 16, AW = 4;

   logic               clk = 1'b0, rst = 1'b1;
   logic               load_start = 1'b0, wr_valid = 1'b0, run_start = 1'b0, out_ready = 1'b0;
   logic [AW:0]        load_num_entry = '0;
   logic [PW-1:0]      wr_data = '0;
   logic               wr_ready, load_done, out_valid, out_last_beat, busy, done, err;
   logic [NC*CW-1:0]   out_ctrl;
   logic [NC*PW-1:0]   out_imm;
   logic [LW-1:0]      out_itr;
   logic [3*LW-1:0]    out_itr_all;
   logic [AW-1:0]      out_ptr;

   ctrl_sequencer #(.NUM_COL(NC), .PHIT_W(PW), .CTRL_W(CW), .DEPTH(DP), .LOOP_W(LW)) dut (
      .clk(clk), .rst(rst), .load_start(load_start), .load_num_entry(load_num_entry),
      .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready), .load_done(load_done),
      .run_start(run_start), .out_valid(out_valid), .out_ready(out_ready),
      .out_ctrl(out_ctrl), .out_imm(out_imm), .out_itr(out_itr), .out_itr_all(out_itr_all),
      .out_ptr(out_ptr), .out_last_beat(out_last_beat), .busy(busy), .done(done), .err(err));

   always #5 clk = ~clk;

   typedef struct {
      int           ptr;
      logic [15:0]  itr;
      logic [47:0]  all;
      bit           lb;
   } beat_t;

   int            n_cmp = 0, n_mis = 0;
   logic [63:0]   words[$];
   beat_t         exp_q[$];
   logic [CW-1:0] m_ctrl [DP][NC];
   logic [PW-1:0] m_imm  [DP][NC];

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic add_entry(input int e, input int salt, input int bi, input int bj, input int bk,
                            input logic [1:0] sel, input bit last);
      state_entry_t se;
      logic [63:0]  w;
      se.last = last; se.itr_sel = sel;
      se.bound_i = 16'(bi); se.bound_j = 16'(bj); se.bound_k = 16'(bk);
      w = '0;
      w[$bits(state_entry_t)-1:0] = se;
      words.push_back(w);
      for (int c = 0; c < NC; c++) begin
         m_ctrl[e][c] = 24'(salt * 256 + e * 16 + c + 24'h300000);
         m_imm[e][c]  = {8'(salt), 24'h5A5A5A, 16'hBEEF, 8'(e), 8'(c)};
         words.push_back({40'hDEAD_F00D_77, m_ctrl[e][c]});
         words.push_back(m_imm[e][c]);
      end
   endtask

   task automatic add_beat(input int p, input int i, input int j, input int k,
                           input int itr, input bit lb);
      beat_t b;
      b.ptr = p; b.itr = 16'(itr); b.all = {16'(i), 16'(j), 16'(k)}; b.lb = lb;
      exp_q.push_back(b);
   endtask

   task automatic do_load(input int n);
      load_start = 1'b1; load_num_entry = 5'(n);
      tick();
      load_start = 1'b0;
      chk("ld_busy", busy, 1);
      chk("ld_ready", wr_ready, 1);
      for (int w = 0; w < words.size(); w++) begin
         if (w % 3 == 1) begin
            wr_valid = 1'b0;
            tick();
            chk("ld_gap_done", load_done, 0);
         end
         wr_valid = 1'b1; wr_data = words[w];
         tick();
         if (w != words.size() - 1) begin
            chk("ld_early_done", load_done, 0);
         end else begin
            chk("ld_done", load_done, 1);
            chk("ld_ready_off", wr_ready, 0);
            chk("ld_busy_off", busy, 0);
         end
      end
      wr_valid = 1'b0;
      tick();
      chk("ld_done_pulse", load_done, 0);
   endtask

   task automatic run_seq(input bit toggle, input int max_ptr);
      int idx = 0, cyc = 0, hi_ptr = 0;
      bit rdy;
      run_start = 1'b1;
      tick();
      run_start = 1'b0;
      while (!done && cyc < 200) begin
         if (int'(out_ptr) > hi_ptr) hi_ptr = int'(out_ptr);
         if (out_valid) begin
            if (idx < exp_q.size()) begin
               chk("itr", out_itr, exp_q[idx].itr);
               chk("itr_all", out_itr_all, exp_q[idx].all);
               chk("ptr", out_ptr, exp_q[idx].ptr);
               chk("last_beat", out_last_beat, exp_q[idx].lb);
               chk("ctrl", out_ctrl, {m_ctrl[exp_q[idx].ptr][1], m_ctrl[exp_q[idx].ptr][0]});
               chk("imm", out_imm, {m_imm[exp_q[idx].ptr][1], m_imm[exp_q[idx].ptr][0]});
            end else begin
               chk("extra_beat", idx, exp_q.size() - 1);
            end
         end
         rdy = toggle ? (cyc % 2 == 0) : 1'b1;
         out_ready = rdy;
         if (out_valid && rdy) idx++;
         cyc++;
         tick();
      end
      chk("done_seen", done, 1);
      chk("beat_count", idx, exp_q.size());
      chk("max_ptr", hi_ptr, max_ptr);
      out_ready = 1'b1;
      tick();
      chk("done_pulse", done, 0);
      chk("idle_busy", {busy, out_valid}, 0);
   endtask

   initial begin
      repeat (3) tick();
      rst = 1'b0;
      tick();
      chk("rst_ctl", {out_valid, busy, done, err, wr_ready, load_done, out_last_beat}, 0);
      chk("rst_data", {out_ctrl, out_imm, out_itr, out_itr_all, out_ptr}, 0);

      // illegal commands in IDLE
      load_start = 1'b1; load_num_entry = 5'd0;
      tick();
      load_start = 1'b0;
      chk("err_n0", err, 1);
      chk("err_n0_idle", busy, 0);
      tick();
      chk("err_pulse", err, 0);
      load_start = 1'b1; load_num_entry = 5'd17;
      tick();
      load_start = 1'b0;
      chk("err_n17", {err, busy}, 2'b10);
      run_start = 1'b1;
      tick();
      run_start = 1'b0;
      chk("err_run_idle", {err, busy}, 2'b10);
      tick();

      // two entries: (2,1,3) sel k, then (1,2,2) sel beat
      words.delete();
      add_entry(0, 1, 2, 1, 3, ITR_SEL_K, 1'b0);
      add_entry(1, 1, 1, 2, 2, ITR_SEL_BEAT, 1'b0);
      do_load(2);
      exp_q.delete();
      add_beat(0, 0, 0, 0, 0, 0); add_beat(0, 0, 0, 1, 1, 0); add_beat(0, 0, 0, 2, 2, 0);
      add_beat(0, 1, 0, 0, 0, 0); add_beat(0, 1, 0, 1, 1, 0); add_beat(0, 1, 0, 2, 2, 1);
      add_beat(1, 0, 0, 0, 0, 0); add_beat(1, 0, 0, 1, 1, 0);
      add_beat(1, 0, 1, 0, 2, 0); add_beat(1, 0, 1, 1, 3, 1);
      run_seq(1'b0, 1);
      run_seq(1'b1, 1);
      run_seq(1'b0, 1);

      // zero-trip entry 0, last flag on entry 1, entry 2 never reached
      words.delete();
      add_entry(0, 2, 1, 0, 2, ITR_SEL_I, 1'b0);
      add_entry(1, 2, 1, 2, 1, ITR_SEL_J, 1'b1);
      add_entry(2, 2, 1, 1, 1, ITR_SEL_I, 1'b0);
      do_load(3);
      exp_q.delete();
      add_beat(1, 0, 0, 0, 0, 0); add_beat(1, 0, 1, 0, 1, 1);
      run_seq(1'b0, 1);

      // async reset while stalled in RUN
      out_ready = 1'b0;
      run_start = 1'b1;
      tick();
      run_start = 1'b0;
      for (int t = 0; t < 10 && !out_valid; t++) tick();
      chk("pre_rst_valid", out_valid, 1);
      #2 rst = 1'b1;
      #1;
      chk("rst_mid_valid", out_valid, 0);
      chk("rst_mid_ptr", {busy, out_ptr}, 0);
      tick();
      rst = 1'b0;
      out_ready = 1'b1;
      tick();
      run_start = 1'b1;
      tick();
      run_start = 1'b0;
      chk("err_run_after_rst", {err, busy}, 2'b10);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/ctrl_sequencer.md
Name: ctrl_sequencer

Overview:
Parametrised next-generation control plane for the ACiS compute columns.
- Loads a state table plus per-column ctrl/imm config tables from a phit stream, using a valid/ready handshake.
- Sequences through the loaded entries, running a full three-level loop nest (i, j, k) per entry, and issues one ctrl/imm beat per iteration to the column datapath under out_valid/out_ready.
- Adds a per-entry selectable iterator output, zero-trip skipping, early-exit via a last flag, and reload/rerun without reset.

Parameters:
NUM_COL, 4, number of compute columns (config tables)
PHIT_W, 64, load word width and imm width per column
CTRL_W, 24, ctrl word width per column (low CTRL_W bits of a load word)
DEPTH, 16, entries per table; ADDR_W = $clog2(DEPTH)
LOOP_W, 16, loop bound/iterator width; elaboration error unless 3*LOOP_W+3 <= PHIT_W

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
load_start  in  1  begin table load (pulse)
load_num_entry  in  ADDR_W+1  entries to load, sampled with load_start, legal 1..DEPTH
wr_data  in  PHIT_W  load word
wr_valid  in  1  load word valid
wr_ready  out  1  loader accepts word
load_done  out  1  one-cycle pulse after last word written
run_start  in  1  begin sequencing (pulse)
out_valid  out  1  beat valid
out_ready  in  1  datapath accepts beat
out_ctrl  out  NUM_COL*CTRL_W  column c at [c*CTRL_W +: CTRL_W]
out_imm  out  NUM_COL*PHIT_W  column c at [c*PHIT_W +: PHIT_W]
out_itr  out  LOOP_W  iterator chosen by entry itr_sel
out_itr_all  out  3*LOOP_W  {i,j,k}
out_ptr  out  ADDR_W  current entry index
out_last_beat  out  1  final beat of current entry
busy  out  1  state is LOAD, FETCH or RUN
done  out  1  one-cycle pulse, sequence complete
err  out  1  one-cycle pulse on illegal command

Behaviour:
Reset values:
- All outputs 0; FSM to IDLE; loaded flag cleared.
- Table storage is not reset.

State word layout:
- [LOOP_W-1:0] bound_k, [2L-1:L] bound_j, [3L-1:2L] bound_i (L = LOOP_W).
- [3L+1:3L] itr_sel, [3L+2] last.

Load word order per entry: state word, then for c = 0..NUM_COL-1: ctrl_c, imm_c. That is 1+2*NUM_COL words per entry; entries are written to addresses 0..N-1.

FSM:
- IDLE:
  - load_start with N in 1..DEPTH -> LOAD.
  - load_start with N illegal -> err pulse, stay IDLE.
  - run_start -> err pulse, stay IDLE.
- LOAD:
  - wr_ready=1. A word is written when wr_valid && wr_ready.
  - Word and entry counters advance only on accept.
  - Acceptance of the final word -> LOADED next cycle, with load_done high for that one cycle and loaded flag set.
  - run_start and load_start are ignored.
- LOADED:
  - run_start -> FETCH with ptr=0, i=j=k=0.
  - load_start -> LOAD (reload), with the same legality check as IDLE.
  - If both are asserted the same cycle, load_start wins.
- FETCH (1 cycle):
  - If entry[ptr] has any zero bound, the entry is skipped with no beats. Then: if last or ptr==N-1 -> DONE, else ptr++ and stay in FETCH.
  - Otherwise -> RUN.
- RUN:
  - out_valid=1. out_ctrl/out_imm/out_itr come from entry[ptr] and the counters.
  - All outputs hold stable while out_valid && !out_ready.
  - Handshake advances the nest k -> j -> i, wrapping at bound-1.
  - out_last_beat = (i,j,k) == (bound_i-1, bound_j-1, bound_k-1).
  - On the last beat's handshake: if last or ptr==N-1 -> DONE, else ptr++, counters 0, -> FETCH.
  - load_start and run_start are ignored.
- DONE: done pulse, -> LOADED. Tables are retained, so a rerun is allowed.

itr_sel mapping:
- 0 -> i, 1 -> j, 2 -> k.
- 3 -> linear beat count within the entry, modulo 2^LOOP_W, reset at each FETCH.

Throughput: one beat per cycle when out_ready=1; a one-cycle FETCH bubble between entries.

rst asserted mid-operation: immediate return to reset values; a subsequent run_start without a reload produces err.

Decomposition:
- Package acis_ctrl_pkg:
  - Default parameters.
  - Packed state_entry_t struct (bounds, itr_sel, last).
  - FSM enum (IDLE, LOAD, LOADED, FETCH, RUN, DONE).
  - itr_sel encodings.
- Sub-module loop_nest_counter:
  - Inputs: clr, adv, bound_i/j/k.
  - Outputs: i, j, k, beat count, last flag.
  - Instantiated once.

Test Plan:
- Load, NUM_COL=2: N=2, 10 words with wr_valid gaps -> load_done exactly one cycle after the 10th accept; wr_ready=0 thereafter; busy=1 only during LOAD.
- Run, loop nest: entry0 bounds (i,j,k)=(2,1,3), sel=2, out_ready=1 -> 6 beats with out_itr 0,1,2,0,1,2 and out_last_beat on beat 6. Entry1 uses sel=3, bounds (1,2,2) -> out_itr 0,1,2,3. done pulses once.
- Backpressure: toggle out_ready 1/0 every cycle -> out_* stable during stalls; total beat count unchanged.
- Zero-trip and last flag: 3 entries, entry0 bound_j=0 -> no beats for ptr 0. Entry1 last=1 -> done after entry1; ptr never reaches 2.
- Errors: load_start with N=0 -> err pulse, stays IDLE. N=DEPTH+1 -> err. run_start in IDLE -> err.
- Reset and rerun: rst mid-RUN -> out_valid=0 immediately, run_start then gives err. Separately, run_start again after done -> identical beat sequence.
